// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_pkg
// Description : Shared constants and bus-slicing helpers for the multi-port
//               integer register file.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef REGFILE_MP_PKG_SV
`define REGFILE_MP_PKG_SV

// Extract element IDX of width W from a flattened bus.
`define RF_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package regfile_mp_pkg;

    // Default geometry of the RV32I integer file.
    localparam int c_XLEN_DEFAULT  = 32;
    localparam int c_NREGS_DEFAULT = 32;

    // Architectural zero register: reads as 0, never written, never busy.
    localparam int c_ZERO_REG = 0;

endpackage

`endif

`default_nettype wire

// File: rtl/regfile_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arb
// Description : Combinational write-port match for one query address.
//               Reports whether any enabled write port targets the address,
//               the data of the highest-indexed matching port, and whether
//               two or more enabled ports collide on it. Address 0 never
//               matches.
// Revision    : 1.0 - initial release
// ============================================================================

module regfile_wr_arb
    import regfile_mp_pkg::*;
#(
    parameter int XLEN   = c_XLEN_DEFAULT,
    parameter int AW     = 5,
    parameter int NWRITE = 2
) (
    input  logic [NWRITE-1:0]      i_wr_en,
    input  logic [NWRITE*AW-1:0]   i_wr_addr,
    input  logic [NWRITE*XLEN-1:0] i_wr_data,
    input  logic [AW-1:0]          i_query_addr,
    output logic                   o_hit,
    output logic [XLEN-1:0]        o_data,
    output logic                   o_collision
);

    logic            w_query_nz;
    logic            w_hit;
    logic [XLEN-1:0] w_data;
    logic            w_collision;

    assign w_query_nz = (i_query_addr != AW'(c_ZERO_REG));

    // Scan ports in ascending order so the highest-indexed match wins.
    always_comb begin
        w_hit       = 1'b0;
        w_data      = '0;
        w_collision = 1'b0;
        for (int w = 0; w < NWRITE; w++) begin
            if (i_wr_en[w] && w_query_nz &&
                (`RF_SLICE(i_wr_addr, w, AW) == i_query_addr)) begin
                if (w_hit) begin
                    w_collision = 1'b1;
                end
                w_hit  = 1'b1;
                w_data = `RF_SLICE(i_wr_data, w, XLEN);
            end
        end
    end

    assign o_hit       = w_hit;
    assign o_data      = w_data;
    assign o_collision = w_collision;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port integer register file with optional
//               write-to-read bypass, per-register busy scoreboard and a
//               registered write-collision flag. Register 0 is hard zero.
// Revision    : 1.0 - initial release
// ============================================================================

module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN   = c_XLEN_DEFAULT,
    parameter int NREGS  = c_NREGS_DEFAULT,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]       rd_busy,
    input  logic [NWRITE-1:0]      wr_en,
    input  logic [NWRITE*AW-1:0]   wr_addr,
    input  logic [NWRITE*XLEN-1:0] wr_data,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_rd,
    output logic                   wr_conflict
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [XLEN-1:0]  r_regs_q [NREGS];
    logic [XLEN-1:0]  w_regs_d [NREGS];
    logic [NREGS-1:0] r_busy_q;
    logic [NREGS-1:0] w_busy_d;
    logic             r_conflict_q;
    logic             w_conflict_d;

    // ------------------------------------------------------------------------
    // Per-register write decode: one arbiter per writable register gives its
    // write enable, the winning data and whether ports collided on it.
    // ------------------------------------------------------------------------
    logic [NREGS-1:0] w_reg_we;
    logic [NREGS-1:0] w_reg_coll;
    logic [XLEN-1:0]  w_reg_wdata [NREGS];

    for (genvar r = 0; r < NREGS; r++) begin : g_reg_dec
        if (r == c_ZERO_REG) begin : g_zero
            // The zero register has no write path at all.
            assign w_reg_we[r]    = 1'b0;
            assign w_reg_coll[r]  = 1'b0;
            assign w_reg_wdata[r] = '0;
        end else begin : g_arb
            regfile_wr_arb #(
                .XLEN   (XLEN),
                .AW     (AW),
                .NWRITE (NWRITE)
            ) u_wr_arb (
                .i_wr_en      (wr_en),
                .i_wr_addr    (wr_addr),
                .i_wr_data    (wr_data),
                .i_query_addr (AW'(r)),
                .o_hit        (w_reg_we[r]),
                .o_data       (w_reg_wdata[r]),
                .o_collision  (w_reg_coll[r])
            );
        end
    end

    // Next-state of the storage array: winning write data per register.
    always_comb begin
        w_regs_d = r_regs_q;
        for (int r = 0; r < NREGS; r++) begin
            if (w_reg_we[r]) begin
                w_regs_d[r] = w_reg_wdata[r];
            end
        end
    end

    // Scoreboard next-state: clear on writeback, then set on issue so a new
    // producer supersedes a completing one.
    always_comb begin
        w_busy_d = r_busy_q & ~w_reg_we;
        if (issue_valid && (issue_rd != AW'(c_ZERO_REG))) begin
            w_busy_d[issue_rd] = 1'b1;
        end
        w_busy_d[c_ZERO_REG] = 1'b0;
    end

    // Any register hit by two or more ports this cycle raises the flag.
    always_comb begin
        w_conflict_d = |w_reg_coll;
    end

    // Register storage, scoreboard and conflict flag; reset drops everything
    // presented in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs_q[r] <= '0;
            end
            r_busy_q     <= '0;
            r_conflict_q <= 1'b0;
        end else begin
            r_regs_q     <= w_regs_d;
            r_busy_q     <= w_busy_d;
            r_conflict_q <= w_conflict_d;
        end
    end

    assign wr_conflict = r_conflict_q;

    // ------------------------------------------------------------------------
    // Read ports: zero-latency lookup with optional same-cycle forwarding.
    // ------------------------------------------------------------------------
    logic [NREAD-1:0] w_rd_coll_unused;

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   w_rd_addr;
        logic            w_rd_hit;
        logic [XLEN-1:0] w_rd_byp;
        logic            w_rd_fwd;

        assign w_rd_addr = `RF_SLICE(rd_addr, i, AW);

        regfile_wr_arb #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NWRITE (NWRITE)
        ) u_rd_arb (
            .i_wr_en      (wr_en),
            .i_wr_addr    (wr_addr),
            .i_wr_data    (wr_data),
            .i_query_addr (w_rd_addr),
            .o_hit        (w_rd_hit),
            .o_data       (w_rd_byp),
            .o_collision  (w_rd_coll_unused[i])
        );

        // Forwarding only exists when bypass is enabled; the arbiter already
        // refuses to match address 0.
        assign w_rd_fwd = (BYPASS != 0) && w_rd_hit;

        assign `RF_SLICE(rd_data, i, XLEN) =
            (w_rd_addr == AW'(c_ZERO_REG)) ? '0       :
            w_rd_fwd                       ? w_rd_byp :
                                             r_regs_q[w_rd_addr];

        // A forwarded value is already final, so the reader need not stall.
        assign rd_busy[i] = r_busy_q[w_rd_addr] & ~w_rd_fwd;
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp. Drives a bypassing and a
//               non-bypassing instance with the same stimulus and compares
//               both against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int AW     = 5;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NWRITE-1:0]      wr_en;
    logic [NWRITE*AW-1:0]   wr_addr;
    logic [NWRITE*XLEN-1:0] wr_data;
    logic                   issue_valid;
    logic [AW-1:0]          issue_rd;

    logic [NREAD*XLEN-1:0]  rd_data_b,  rd_data_n;
    logic [NREAD-1:0]       rd_busy_b,  rd_busy_n;
    logic                   wr_conflict_b, wr_conflict_n;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .wr_conflict(wr_conflict_b)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .BYPASS(0)) dut_nob (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .wr_conflict(wr_conflict_n)
    );

    // Reference model state
    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    logic             m_conflict;

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Expected read result from the model plus the inputs of this cycle.
    task automatic exp_read(input logic [AW-1:0] a, input bit byp,
                            output logic [XLEN-1:0] d, output logic b);
        int win;
        win = -1;
        for (int w = 0; w < NWRITE; w++)
            if (wr_en[w] && (wr_addr[w*AW +: AW] == a)) win = w;
        if (a == 0) begin
            d = '0; b = 1'b0;
        end else if (byp && win >= 0) begin
            d = wr_data[win*XLEN +: XLEN]; b = 1'b0;
        end else begin
            d = m_regs[a]; b = m_busy[a];
        end
    endtask

    task automatic check_all();
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;
        for (int i = 0; i < NREAD; i++) begin
            a = rd_addr[i*AW +: AW];
            exp_read(a, 1'b1, d, b);
            check($sformatf("byp rd_data[%0d] x%0d", i, a), rd_data_b[i*XLEN +: XLEN], d);
            check($sformatf("byp rd_busy[%0d] x%0d", i, a), XLEN'(rd_busy_b[i]), XLEN'(b));
            exp_read(a, 1'b0, d, b);
            check($sformatf("nob rd_data[%0d] x%0d", i, a), rd_data_n[i*XLEN +: XLEN], d);
            check($sformatf("nob rd_busy[%0d] x%0d", i, a), XLEN'(rd_busy_n[i]), XLEN'(b));
        end
        check("byp wr_conflict", XLEN'(wr_conflict_b), XLEN'(m_conflict));
        check("nob wr_conflict", XLEN'(wr_conflict_n), XLEN'(m_conflict));
    endtask

    // Advance one clock and apply the architectural rules to the model.
    task automatic tick();
        int              hits [NREGS];
        logic [AW-1:0]   a;
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
            m_busy     = '0;
            m_conflict = 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) hits[r] = 0;
            for (int w = 0; w < NWRITE; w++) begin
                if (wr_en[w]) begin
                    a = wr_addr[w*AW +: AW];
                    m_busy[a] = 1'b0;
                    if (a != 0) begin
                        m_regs[a] = wr_data[w*XLEN +: XLEN];
                        hits[a]++;
                    end
                end
            end
            m_conflict = 1'b0;
            for (int r = 1; r < NREGS; r++) if (hits[r] >= 2) m_conflict = 1'b1;
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0; issue_valid = 1'b0; issue_rd = '0;
    endtask

    task automatic set_wr(input logic [1:0] en, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                          input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
        wr_en = en; wr_addr = {a1, a0}; wr_data = {d1, d0};
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS-1));
        return AW'($urandom_range(0, 5));
    endfunction

    initial begin
        rst = 1'b1; rd_addr = '0; idle();
        tick();
        rst = 1'b0;

        // Reset state: every address on both ports reads 0, not busy.
        for (int a = 0; a < NREGS; a++) begin
            rd_addr = {AW'(NREGS-1-a), AW'(a)};
            #1;
            check_all();
        end
        check("reset wr_conflict", XLEN'(wr_conflict_b), 32'd0);

        // Single write with same-cycle read, then the stored value.
        set_wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
        rd_addr = {5'd5, 5'd5};
        #1;
        check("x5 same-cycle byp", rd_data_b[0 +: XLEN], 32'hDEADBEEF);
        check("x5 same-cycle nob", rd_data_n[0 +: XLEN], 32'h0);
        check_all();
        tick(); idle(); #1;
        check("x5 stored byp", rd_data_b[XLEN +: XLEN], 32'hDEADBEEF);
        check("x5 stored nob", rd_data_n[XLEN +: XLEN], 32'hDEADBEEF);
        check_all();

        // Two ports on x7: port 1 wins, conflict pulses for one cycle.
        set_wr(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
        rd_addr = {5'd0, 5'd7};
        #1;
        check("x7 collide byp fwd", rd_data_b[0 +: XLEN], 32'h22);
        check_all();
        tick(); idle(); #1;
        check("x7 winner", rd_data_n[0 +: XLEN], 32'h22);
        check("conflict pulse", XLEN'(wr_conflict_b), 32'd1);
        check_all();
        tick(); #1;
        check("conflict cleared", XLEN'(wr_conflict_b), 32'd0);
        check_all();

        // Writes to x0 on both ports are dropped and never flag a conflict.
        set_wr(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF);
        rd_addr = {5'd0, 5'd0};
        #1;
        check("x0 same-cycle", rd_data_b[0 +: XLEN], 32'h0);
        check_all();
        tick(); idle(); #1;
        check("x0 stored", rd_data_n[0 +: XLEN], 32'h0);
        check("x0 no conflict", XLEN'(wr_conflict_n), 32'd0);
        check_all();

        // Scoreboard: issue, write+issue (set wins), write alone.
        issue_valid = 1'b1; issue_rd = 5'd3;
        rd_addr = {5'd3, 5'd3};
        tick(); idle(); #1;
        check("x3 busy after issue", XLEN'(rd_busy_n), 32'd3);
        check_all();
        set_wr(2'b01, 5'd3, 32'h33, 5'd0, 32'd0);
        issue_valid = 1'b1; issue_rd = 5'd3;
        #1;
        check("x3 fwd clears busy", XLEN'(rd_busy_b), 32'd0);
        check("x3 nob still busy", XLEN'(rd_busy_n), 32'd3);
        check_all();
        tick(); idle(); #1;
        check("x3 set wins", XLEN'(rd_busy_b), 32'd3);
        check_all();
        set_wr(2'b01, 5'd3, 32'h44, 5'd0, 32'd0);
        tick(); idle(); #1;
        check("x3 released", XLEN'(rd_busy_b), 32'd0);
        check("x3 data", rd_data_b[0 +: XLEN], 32'h44);
        check_all();

        // Reset while x9 is busy; the write in the reset cycle is dropped.
        issue_valid = 1'b1; issue_rd = 5'd9;
        rd_addr = {5'd9, 5'd9};
        tick(); idle(); #1;
        check("x9 busy", XLEN'(rd_busy_n), 32'd3);
        rst = 1'b1;
        set_wr(2'b10, 5'd0, 32'd0, 5'd9, 32'h1234);
        #1;
        check_all();
        tick(); rst = 1'b0; idle(); #1;
        check("x9 busy after rst", XLEN'(rd_busy_n), 32'd0);
        check("x9 data after rst", rd_data_n[0 +: XLEN], 32'h0);
        check_all();

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 49) == 0);
            wr_en       = 2'($urandom);
            wr_addr     = {rnd_addr(), rnd_addr()};
            wr_data     = {$urandom, $urandom};
            issue_valid = 1'($urandom);
            issue_rd    = rnd_addr();
            rd_addr     = {rnd_addr(), rnd_addr()};
            #1;
            check_all();
            tick();
        end
        rst = 1'b0; idle(); #1;
        check_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
